// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  // Arbiter states; StHdr is only entered when the header feature is built in.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHdr   = 2'd1,
    StBurst = 2'd2
  } state_e;

  // Tag placed in the top nibble of every header word.
  localparam logic [3:0] HdrTag = 4'hA;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx
);

  logic        found;
  int unsigned j;

  // Scan from ptr upward, wrapping, and take the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        onehot[j] = 1'b1;
        idx       = IdxW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a shared single-clock FIFO.
// Define ARB_HEADER_EN to prefix each burst with a header word {4'hA, 0.., granted index}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic [NREQ-1:0]       src_req,
  input  logic [NREQ-1:0]       src_valid,
  input  logic [NREQ-1:0]       src_last,
  input  logic [NREQ*WIDTH-1:0] src_data,
  output logic [NREQ-1:0]       src_gnt,
  output logic [NREQ-1:0]       src_ack,
  input  logic                  fifo_full,
  output logic                  fifo_wrreq,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [15:0]           burst_cnt
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef ARB_HEADER_EN
  localparam state_e FirstSt = StHdr;
`else
  localparam state_e FirstSt = StBurst;
`endif

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0]   pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic [WIDTH-1:0]  hdr_word;
  logic [WIDTH-1:0]  lane_data;
  logic              last_acc;

  rr_pick #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_pick (
    .req    (src_req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Header word: tag in the top nibble, granted index in the low bits.
  always_comb begin
    hdr_word                 = '0;
    hdr_word[WIDTH-1 -: 4]   = HdrTag;
    hdr_word[IdxW-1:0]       = gidx_q;
  end

  // Mux the granted requester's lane.
  always_comb begin
    lane_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx_q == IdxW'(i)) lane_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  // FIFO write side and per-word accepts; all zero outside active states so reset clears them.
  always_comb begin
    src_ack    = '0;
    fifo_wrreq = 1'b0;
    fifo_data  = '0;
    last_acc   = 1'b0;
    unique case (state_q)
      StHdr: begin
        fifo_wrreq = !fifo_full;
        fifo_data  = hdr_word;
      end
      StBurst: begin
        src_ack    = gnt_q & src_valid & {NREQ{!fifo_full}};
        fifo_wrreq = |src_ack;
        fifo_data  = lane_data;
        last_acc   = |(src_ack & src_last);
      end
      default: ;
    endcase
  end

  // Next state: grant on request, end the burst only on an accepted last word.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|src_req) begin
          gnt_d   = pick_onehot;
          gidx_d  = pick_idx;
          state_d = FirstSt;
        end
      end
      StHdr: begin
        if (!fifo_full) state_d = StBurst;
      end
      StBurst: begin
        if (last_acc) begin
          gnt_d       = '0;
          state_d     = StIdle;
          rr_ptr_d    = (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + IdxW'(1);
          burst_cnt_d = burst_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign src_gnt   = gnt_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expected FIFO words and grants go to queues,
// a monitor process pops and compares them as the DUT produces them.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
`ifdef ARB_HEADER_EN
  localparam int HdrWords = 1;
`else
  localparam int HdrWords = 0;
`endif

  logic        clock, aclr_n;
  logic [3:0]  src_req, src_valid, src_last, src_gnt, src_ack;
  logic [63:0] src_data;
  logic        fifo_full, fifo_wrreq;
  logic [15:0] fifo_data, burst_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int n_written = 0;

  logic [19:0] exp_q[$];   // {data, ack one-hot}
  logic [3:0]  gntexp_q[$];

  // Requester lane model: per-lane word store {last, data}.
  logic [16:0] lmem [4][16];
  int          lhead [4];
  int          ltail [4];
  logic [3:0]  drop, hold;
  logic [3:0]  prev_gnt;

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .src_req    (src_req),
    .src_valid  (src_valid),
    .src_last   (src_last),
    .src_data   (src_data),
    .src_gnt    (src_gnt),
    .src_ack    (src_ack),
    .fifo_full  (fifo_full),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .burst_cnt  (burst_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  task automatic exp_grant(input int lane);
    gntexp_q.push_back(4'(1 << lane));
`ifdef ARB_HEADER_EN
    exp_q.push_back({16'hA000 | 16'(lane), 4'b0000});
`endif
  endtask

  task automatic exp_word(input logic [15:0] data, input int lane);
    exp_q.push_back({data, 4'(1 << lane)});
  endtask

  task automatic load(input int lane, input int n, input logic [15:0] base);
    if (lhead[lane] == ltail[lane]) begin
      lhead[lane] = 0;
      ltail[lane] = 0;
    end
    for (int k = 0; k < n; k++) begin
      lmem[lane][ltail[lane]] = {(k == n - 1), base + 16'(k)};
      ltail[lane]++;
    end
  endtask

  // Ungranted lanes with data present also raise valid; the DUT has to ignore them.
  task automatic drive();
    logic ne;
    for (int i = 0; i < 4; i++) begin
      ne = (lhead[i] != ltail[i]);
      src_req[i]          = ne && !drop[i];
      src_valid[i]        = ne && !(src_gnt[i] && hold[i]);
      src_last[i]         = ne && lmem[i][lhead[i]][16];
      src_data[i*16 +: 16] = ne ? lmem[i][lhead[i]][15:0] : 16'hDEAD;
    end
  endtask

  // One clock: capture accepts before the edge, retire them after, re-drive at edge+1.
  task automatic step();
    logic [3:0] acc;
    @(negedge clock);
    acc = src_ack;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) lhead[i]++;
    drive();
  endtask

  function automatic logic lanes_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < 4; i++) if (lhead[i] != ltail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic run_idle(input string name, input int limit);
    int c;
    c = 0;
    while (!(lanes_empty() && src_gnt == 4'b0 && exp_q.size() == 0) && c < limit) begin
      step();
      c++;
    end
    chk({name, "_done_in_budget"}, (c < limit), 1);
  endtask

  task automatic run_written(input string name, input int target, input int limit);
    int c;
    c = 0;
    while (n_written < target && c < limit) begin
      step();
      c++;
    end
    chk({name, "_written_in_budget"}, (c < limit), 1);
  endtask

  // Asserts reset mid-cycle, checks outputs clear immediately, releases between edges.
  task automatic do_reset(input string name);
    aclr_n    = 1'b0;
    fifo_full = 1'b0;
    drop      = '0;
    hold      = '0;
    for (int i = 0; i < 4; i++) begin
      lhead[i] = 0;
      ltail[i] = 0;
    end
    drive();
    #1;
    chk({name, "_gnt"}, src_gnt, 0);
    chk({name, "_ack"}, src_ack, 0);
    chk({name, "_wrreq"}, fifo_wrreq, 0);
    chk({name, "_data"}, fifo_data, 0);
    chk({name, "_cnt"}, burst_cnt, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    aclr_n = 1'b1;
    @(posedge clock);
    #1;
    drive();
  endtask

  // Monitor: compares every FIFO write and every new grant against the queues.
  initial begin
    prev_gnt = '0;
    forever begin
      @(negedge clock);
      if (aclr_n) begin
        chk("wr_while_full", fifo_wrreq & fifo_full, 0);
        if (fifo_wrreq) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", fifo_data, 0);
          end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("fifo_data", fifo_data, e[19:4]);
            chk("src_ack", src_ack, e[3:0]);
          end
          n_written++;
        end else begin
          chk("ack_without_write", src_ack, 0);
        end
        if (src_gnt != 4'b0 && src_gnt != prev_gnt) begin
          if (gntexp_q.size() == 0) chk("unexpected_grant", src_gnt, 0);
          else chk("grant_order", src_gnt, gntexp_q.pop_front());
        end
      end
      prev_gnt = src_gnt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    src_req   = '0;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    do_reset("reset0");

    // Single requester 0, 3-word burst.
    exp_grant(0);
    exp_word(16'h0101, 0);
    exp_word(16'h0102, 0);
    exp_word(16'h0103, 0);
    load(0, 3, 16'h0101);
    drive();
    step();
    chk("t31_gnt_next_cycle", src_gnt, 4'b0001);
    run_idle("t31", 40);
    chk("t31_burst_cnt", burst_cnt, 1);

    // Fresh rr_ptr, all four requesting, 2-word bursts: 0,1,2,3,0.
    do_reset("reset1");
    load(0, 2, 16'h0201);
    load(0, 2, 16'h0211);
    load(1, 2, 16'h1201);
    load(2, 2, 16'h2201);
    load(3, 2, 16'h3201);
    exp_grant(0); exp_word(16'h0201, 0); exp_word(16'h0202, 0);
    exp_grant(1); exp_word(16'h1201, 1); exp_word(16'h1202, 1);
    exp_grant(2); exp_word(16'h2201, 2); exp_word(16'h2202, 2);
    exp_grant(3); exp_word(16'h3201, 3); exp_word(16'h3202, 3);
    exp_grant(0); exp_word(16'h0211, 0); exp_word(16'h0212, 0);
    drive();
    run_idle("t32", 120);
    chk("t32_burst_cnt", burst_cnt, 5);

    // FIFO full for 5 cycles after two words of a 4-word burst on lane 1.
    base = n_written;
    exp_grant(1);
    exp_word(16'h1301, 1); exp_word(16'h1302, 1);
    exp_word(16'h1303, 1); exp_word(16'h1304, 1);
    load(1, 4, 16'h1301);
    drive();
    run_written("t33", base + HdrWords + 2, 30);
    fifo_full = 1'b1;
    repeat (5) begin
      #1;
      chk("t33_ack_during_full", src_ack, 0);
      chk("t33_wrreq_during_full", fifo_wrreq, 0);
      chk("t33_gnt_held", src_gnt, 4'b0010);
      step();
    end
    fifo_full = 1'b0;
    run_idle("t33", 40);
    chk("t33_burst_cnt", burst_cnt, 6);

    // Reset during word 2 of a 4-word burst on lane 2 (rr_ptr is 2 at this point).
    base = n_written;
    exp_grant(2);
    exp_word(16'h2401, 2);
    load(2, 4, 16'h2401);
    drive();
    run_written("t34", base + HdrWords + 1, 30);
    do_reset("t34_reset");
    load(0, 2, 16'h0501);
    load(2, 1, 16'h2501);
    exp_grant(0); exp_word(16'h0501, 0); exp_word(16'h0502, 0);
    exp_grant(2); exp_word(16'h2501, 2);
    drive();
    step();
    chk("t34_next_grant_idx0", src_gnt, 4'b0001);
    run_idle("t34", 40);
    chk("t34_burst_cnt", burst_cnt, 2);

    // Lane 1 drops req after grant and stalls valid for 3 cycles; 6-word burst.
    base = n_written;
    exp_grant(1);
    exp_word(16'h1601, 1); exp_word(16'h1602, 1); exp_word(16'h1603, 1);
    exp_word(16'h1604, 1); exp_word(16'h1605, 1); exp_word(16'h1606, 1);
    load(1, 6, 16'h1601);
    drive();
    step();
    chk("t36_gnt", src_gnt, 4'b0010);
    drop[1] = 1'b1;
    drive();
    step();
    step();
    hold[1] = 1'b1;
    drive();
    repeat (3) begin
      #1;
      chk("t36_wrreq_stalled", fifo_wrreq, 0);
      chk("t36_gnt_stalled", src_gnt, 4'b0010);
      step();
    end
    hold[1] = 1'b0;
    drive();
    begin
      int c;
      c = 0;
      while (n_written < base + HdrWords + 5 && c < 30) begin
        chk("t36_gnt_held", src_gnt, 4'b0010);
        step();
        c++;
      end
      chk("t36_five_in_budget", (c < 30), 1);
    end
    chk("t36_gnt_before_last", src_gnt, 4'b0010);
    step();
    chk("t36_gnt_released", src_gnt, 0);
    chk("t36_burst_cnt", burst_cnt, 3);
    drop[1] = 1'b0;
    run_idle("t36", 20);

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("grant_queue_drained", gntexp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
